menu_video_timing: RTL and testbench

Upstream video source for the menu core's scandoubler. Generates 15 kHz PAL-style timing and a pixel clock enable from `clk_sys`. Fetches one 8-bit RRRGGGBB pixel per active pixel from an external framebuffer and expands it to 6-bit RGB. Drives `hb/vb/hs/vs/r/g/b` directly into the scandoubler's `_in` ports and uses the same `ce_divider` encoding.

---
 rtl/menu_video_timing.sv | 182 ++++++++++++++++++
 tb/tb_menu_video_timing.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_video_timing.sv
// 15 kHz PAL-style timing generator and framebuffer pixel fetcher for the menu scandoubler.
// Optional colour-bar substitution is built only when MENU_VGEN_TESTPAT_EN is defined.
module menu_video_timing #(
    parameter int H_ACTIVE = 256,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 56,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 61,
    parameter int ADDR_W   = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [2:0]        ce_divider,
    input  logic              test_pattern,
    output logic              ce_pix,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              hb,
    output logic              vb,
    output logic              hs,
    output logic              vs,
    output logic [5:0]        r,
    output logic [5:0]        g,
    output logic [5:0]        b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [2:0]    div_cnt;
    logic [2:0]    div_eff;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap, v_wrap;
    logic          hb_r, vb_r, hs_r, vs_r, active;

    assign ce_pix = (div_cnt == div_eff);
    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);
    assign hb_r   = (h >= H_ACT_END);
    assign hs_r   = !((h >= HS_START) && (h < HS_END));
    assign vb_r   = (v >= V_ACT_END);
    // v only moves on a line wrap, so vs_r can only change on h==0 ticks
    assign vs_r   = !((v >= VS_START) && (v < VS_END));
    assign active = !hb_r && !vb_r;
    assign fb_rd  = ce_pix && active;

    // New divider only lands at line start; div_cnt restarts at the same tick
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= 3'd0;
            div_eff <= 3'd3;
        end else if (ce_pix) begin
            div_cnt <= 3'd0;
            if (h_wrap)
                div_eff <= (ce_divider != 3'd0) ? ce_divider : 3'd3;
        end else begin
            div_cnt <= div_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (ce_pix) begin
            if (h_wrap) begin
                h <= '0;
                v <= v_wrap ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // Linear address walks the active raster, so v*H_ACTIVE+h needs no multiplier
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            fb_addr <= '0;
        else if (ce_pix) begin
            if (h_wrap && v_wrap)
                fb_addr <= '0;
            else if (active)
                fb_addr <= fb_addr + 1'b1;
        end
    end

    logic       rd_d;
    logic [7:0] pix_hold;
    logic       hb_d, vb_d, hs_d, vs_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_d     <= 1'b0;
            pix_hold <= 8'd0;
            hb_d     <= 1'b1;
            vb_d     <= 1'b1;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
        end else begin
            rd_d <= fb_rd;
            if (rd_d)
                pix_hold <= fb_data;
            if (ce_pix) begin
                hb_d <= hb_r;
                vb_d <= vb_r;
                hs_d <= hs_r;
                vs_d <= vs_r;
            end
        end
    end

    logic [5:0] r_n, g_n, b_n;

`ifdef MENU_VGEN_TESTPAT_EN
    logic [2:0] idx_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            idx_d <= 3'd0;
        else if (ce_pix)
            idx_d <= h[7:5];
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
`endif

    always_comb begin
        r_n = {pix_hold[7:5], pix_hold[7:5]};
        g_n = {pix_hold[4:2], pix_hold[4:2]};
        b_n = {pix_hold[1:0], pix_hold[1:0], pix_hold[1:0]};
`ifdef MENU_VGEN_TESTPAT_EN
        if (test_pattern) begin
            r_n = {6{idx_d[2]}};
            g_n = {6{idx_d[1]}};
            b_n = {6{idx_d[0]}};
        end
`endif
        if (hb_d || vb_d) begin
            r_n = 6'd0;
            g_n = 6'd0;
            b_n = 6'd0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hb <= 1'b1;
            vb <= 1'b1;
            hs <= 1'b1;
            vs <= 1'b1;
            r  <= 6'd0;
            g  <= 6'd0;
            b  <= 6'd0;
        end else if (ce_pix) begin
            hb <= hb_d;
            vb <= vb_d;
            hs <= hs_d;
            vs <= vs_d;
            r  <= r_n;
            g  <= g_n;
            b  <= b_n;
        end
    end

endmodule

// File: tb/tb_menu_video_timing.sv
// Bench for menu_video_timing: full-width lines, shortened frame (20 lines) to keep runs short.
module tb_menu_video_timing;

    localparam int HA = 256, HF = 40, HSY = 32, HBP = 56;
    localparam int VA = 12, VF = 2, VSY = 3, VBP = 3;
    localparam int HT = HA + HF + HSY + HBP;
    localparam int VT = VA + VF + VSY + VBP;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  ce_divider = 3'd3;
    logic        test_pattern = 1'b0;
    logic        ce_pix, fb_rd;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic        hb, vb, hs, vs;
    logic [5:0]  r, g, b;

    int tests = 0;
    int fails = 0;

    always #5 clk_sys = ~clk_sys;

    // Framebuffer: each byte holds the low 8 bits of its own address
    always @(posedge clk_sys) if (fb_rd) fb_data <= fb_addr[7:0];

    menu_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VBP), .ADDR_W(16)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_divider(ce_divider),
        .test_pattern(test_pattern), .ce_pix(ce_pix), .fb_rd(fb_rd),
        .fb_addr(fb_addr), .fb_data(fb_data), .hb(hb), .vb(vb), .hs(hs),
        .vs(vs), .r(r), .g(g), .b(b)
    );

    typedef struct packed {
        logic       hb, vb, hs, vs;
        logic [5:0] r, g, b;
    } exp_t;

    // Expected output word for the pixel read on tick k after reset (no test pattern)
    function automatic exp_t model(int k);
        exp_t e;
        int h, v;
        logic [15:0] a;
        logic [7:0]  d;
        h = k % HT;
        v = (k / HT) % VT;
        a = 16'(v * HA + h);
        d = a[7:0];
        e.hb = (h >= HA);
        e.vb = (v >= VA);
        e.hs = !((h >= HA + HF) && (h < HA + HF + HSY));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VSY));
        e.r  = {d[7:5], d[7:5]};
        e.g  = {d[4:2], d[4:2]};
        e.b  = {d[1:0], d[1:0], d[1:0]};
        if (e.hb || e.vb) begin
            e.r = 6'd0; e.g = 6'd0; e.b = 6'd0;
        end
        return e;
    endfunction

    // Reset released just after a falling edge; tick 0 is the 4th rising edge after release
    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        ce_divider = 3'd3;
        do_reset();
        repeat (600) @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        tests++; if (ce_pix !== 1'b0) begin fails++; $display("FAIL reset_ce_pix got=%b exp=0", ce_pix); end
        tests++; if (fb_rd !== 1'b0) begin fails++; $display("FAIL reset_fb_rd got=%b exp=0", fb_rd); end
        tests++; if (fb_addr !== 16'd0) begin fails++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr); end
        tests++; if ({hb, vb, hs, vs} !== 4'b1111) begin fails++; $display("FAIL reset_syncs got=%b exp=1111", {hb, vb, hs, vs}); end
        tests++; if ({r, g, b} !== 18'd0) begin fails++; $display("FAIL reset_rgb got=%h exp=0", {r, g, b}); end
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk_sys);
            n++;
            if (ce_pix === 1'b1) break;
        end
        // ce_pix occupies the 4th clock period after release
        tests++; if (n !== 3) begin fails++; $display("FAIL reset_first_ce got=%0d exp=3 negedges", n); end
        tests++; if ({fb_rd, fb_addr} !== {1'b1, 16'd0}) begin fails++; $display("FAIL reset_first_read got=%b/%0d exp=1/0", fb_rd, fb_addr); end
    endtask

    task automatic test_line_timing();
        int hs_f[$], hs_r[$], hb_r[$], hb_f[$];
        logic phs, phb;
        ce_divider = 3'd3;
        do_reset();
        phs = hs; phb = hb;
        for (int c = 0; c < 3600; c++) begin
            @(negedge clk_sys);
            if (phs && !hs) hs_f.push_back(c);
            if (!phs && hs) hs_r.push_back(c);
            if (!phb && hb) hb_r.push_back(c);
            if (phb && !hb) hb_f.push_back(c);
            phs = hs; phb = hb;
        end
        tests++;
        if (hs_f.size() < 2 || hs_r.size() < 1 || hb_r.size() < 1 || hb_f.size() < 2) begin
            fails++; $display("FAIL line_edges got=%0d/%0d/%0d/%0d edges exp>=2/1/1/2", hs_f.size(), hs_r.size(), hb_r.size(), hb_f.size());
        end else begin
            tests++; if (hs_r[0] - hs_f[0] !== 128) begin fails++; $display("FAIL line_hs_low got=%0d exp=128", hs_r[0] - hs_f[0]); end
            tests++; if (hs_f[1] - hs_f[0] !== 1536) begin fails++; $display("FAIL line_period got=%0d exp=1536", hs_f[1] - hs_f[0]); end
            tests++; if (hb_f[1] - hb_r[0] !== 512) begin fails++; $display("FAIL line_hb_high got=%0d exp=512", hb_f[1] - hb_r[0]); end
        end
    endtask

    task automatic test_frame_timing();
        int vs_f[$], vs_r[$], vb_r[$], vb_f[$], hs_f[$];
        logic pvs, pvb, phs;
        int nhs;
        ce_divider = 3'd1;
        do_reset();
        pvs = vs; pvb = vb; phs = hs;
        for (int c = 0; c < 32800; c++) begin
            @(negedge clk_sys);
            if (pvs && !vs) vs_f.push_back(c);
            if (!pvs && vs) vs_r.push_back(c);
            if (!pvb && vb) vb_r.push_back(c);
            if (pvb && !vb) vb_f.push_back(c);
            if (phs && !hs) hs_f.push_back(c);
            pvs = vs; pvb = vb; phs = hs;
        end
        tests++;
        if (vs_f.size() < 2 || vs_r.size() < 1 || vb_r.size() < 1 || vb_f.size() < 2) begin
            fails++; $display("FAIL frame_edges got=%0d/%0d/%0d/%0d edges exp>=2/1/1/2", vs_f.size(), vs_r.size(), vb_r.size(), vb_f.size());
        end else begin
            nhs = 0;
            foreach (hs_f[i]) if (hs_f[i] > vs_f[0] && hs_f[i] <= vs_f[1]) nhs++;
            tests++; if (vs_r[0] - vs_f[0] !== 3 * HT * 2) begin fails++; $display("FAIL frame_vs_low got=%0d exp=%0d", vs_r[0] - vs_f[0], 3 * HT * 2); end
            tests++; if (vb_f[1] - vb_r[0] !== (VT - VA) * HT * 2) begin fails++; $display("FAIL frame_vb_high got=%0d exp=%0d", vb_f[1] - vb_r[0], (VT - VA) * HT * 2); end
            tests++; if (nhs !== VT) begin fails++; $display("FAIL frame_hs_count got=%0d exp=%0d", nhs, VT); end
            tests++; if (vs_f[1] - vs_f[0] !== VT * HT * 2) begin fails++; $display("FAIL frame_period got=%0d exp=%0d", vs_f[1] - vs_f[0], VT * HT * 2); end
        end
    endtask

    task automatic test_pixel_path();
        exp_t q[$];
        exp_t e;
        int tk, pop_idx, h, v;
        logic was_tick, exp_rd;
        logic [15:0] exp_addr;
        ce_divider = 3'd3;
        do_reset();
        tk = 0; pop_idx = 0; was_tick = 1'b0;
        for (int c = 0; c < 3200; c++) begin
            @(negedge clk_sys);
            // Outputs loaded on the last tick carry the pixel read one tick earlier
            if (was_tick && q.size() >= 2) begin
                e = q.pop_front();
                tests++;
                if ({hb, vb, hs, vs, r, g, b} !== e) begin
                    fails++;
                    $display("FAIL pixel_out pix=%0d got=%b%b%b%b/%0d/%0d/%0d exp=%b%b%b%b/%0d/%0d/%0d",
                             pop_idx, hb, vb, hs, vs, r, g, b, e.hb, e.vb, e.hs, e.vs, e.r, e.g, e.b);
                end
                if (pop_idx == HT + 5) begin
                    tests++;
                    if ({r, g, b} !== {6'd0, 6'd9, 6'd21}) begin
                        fails++; $display("FAIL pixel_h5_v1 got=%0d/%0d/%0d exp=0/9/21", r, g, b);
                    end
                end
                pop_idx++;
            end
            was_tick = ce_pix;
            h = tk % HT;
            v = (tk / HT) % VT;
            exp_rd = ce_pix && (h < HA) && (v < VA);
            exp_addr = 16'(v * HA + h);
            tests++;
            if (fb_rd !== exp_rd || (exp_rd && fb_addr !== exp_addr)) begin
                fails++; $display("FAIL fetch tick=%0d got=%b/%0d exp=%b/%0d", tk, fb_rd, fb_addr, exp_rd, exp_addr);
            end
            if (ce_pix) begin
                q.push_back(model(tk));
                tk++;
            end
        end
    endtask

    task automatic test_divider();
        int tk, last, cyc, expd;
        ce_divider = 3'd0;
        do_reset();
        tk = 0; last = -1; cyc = 0;
        while (tk <= 390 && cyc < 3000) begin
            @(negedge clk_sys);
            cyc++;
            if (ce_pix) begin
                if (last >= 0) begin
                    expd = (tk <= HT - 1) ? 4 : 6;
                    tests++;
                    if (cyc - last !== expd) begin
                        fails++; $display("FAIL div_period tick=%0d got=%0d exp=%0d", tk, cyc - last, expd);
                    end
                end
                last = cyc;
                tk++;
            end
            if (tk == 10) ce_divider = 3'd5;
        end
        tests++;
        if (tk <= 390) begin fails++; $display("FAIL div_timeout got=%0d ticks exp=391", tk); end
        ce_divider = 3'd3;
    endtask

    task automatic test_pattern_bars();
        int tk, cyc;
        logic [17:0] exp_bar;
        logic seen_rd, seen_bar, seen_blank;
`ifdef MENU_VGEN_TESTPAT_EN
        exp_bar = {6'd0, 6'd63, 6'd63};
`else
        exp_bar = {6'd27, 6'd9, 6'd0};
`endif
        ce_divider = 3'd3;
        test_pattern = 1'b1;
        do_reset();
        tk = 0; cyc = 0;
        seen_rd = 1'b0; seen_bar = 1'b0; seen_blank = 1'b0;
        while (cyc < 1400 && !(seen_bar && seen_blank)) begin
            @(negedge clk_sys);
            cyc++;
            if (ce_pix) begin
                if (tk == 100) begin
                    seen_rd = 1'b1;
                    tests++;
                    if (fb_rd !== 1'b1) begin fails++; $display("FAIL tp_fb_rd got=%b exp=1", fb_rd); end
                end
                tk++;
                @(negedge clk_sys);
                cyc++;
                // tk-2 is the pixel now on the outputs
                if (tk - 2 == 100) begin
                    seen_bar = 1'b1;
                    tests++;
                    if ({r, g, b} !== exp_bar) begin fails++; $display("FAIL tp_bar3 got=%0d/%0d/%0d exp=%h", r, g, b, exp_bar); end
                end
                if (tk - 2 == 300) begin
                    seen_blank = 1'b1;
                    tests++;
                    if ({hb, r, g, b} !== {1'b1, 18'd0}) begin fails++; $display("FAIL tp_blank got=%b/%h exp=1/0", hb, {r, g, b}); end
                end
            end
        end
        tests++;
        if (!(seen_rd && seen_bar && seen_blank)) begin
            fails++; $display("FAIL tp_timeout got=%b%b%b exp=111", seen_rd, seen_bar, seen_blank);
        end
        test_pattern = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_pixel_path();
        test_divider();
        test_pattern_bars();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
